// File: rtl/trafficgen_core.sv
// trafficgen_core: AXI-Stream packet generator with programmable length, gap,
// packet count and data pattern. Configuration is captured when a run starts,
// so register writes during a run have no effect until the next one.
module trafficgen_core #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_WIDTH  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cfg_enable,
  input  logic [1:0]              cfg_mode,
  input  logic [LEN_WIDTH-1:0]    cfg_pkt_len,
  input  logic [GAP_WIDTH-1:0]    cfg_gap_len,
  input  logic [CNT_WIDTH-1:0]    cfg_pkt_count,
  input  logic [DATA_WIDTH-1:0]   cfg_seed,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    stat_busy,
  output logic                    stat_done,
  output logic [CNT_WIDTH-1:0]    stat_pkts,
  output logic [CNT_WIDTH-1:0]    stat_beats
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic [1:0] MODE_INCR  = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_INDEX = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [31:0]           lfsr_q, lfsr_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CNT_WIDTH-1:0]  pkts_q, pkts_d;
  logic [CNT_WIDTH-1:0]  beats_q, beats_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  last_beat;
  logic [CNT_WIDTH-1:0]  pkts_inc;
  logic [31:0]           seed32;
  logic [DATA_WIDTH-1:0] lfsr_rep;
  logic [DATA_WIDTH-1:0] pattern;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

  assign last_beat = (beat_cnt_q == len_q - LEN_WIDTH'(1));
  assign pkts_inc  = pkts_q + CNT_WIDTH'(1);
  assign seed32    = 32'(cfg_seed);

  // Next-state, shadow-register capture, pattern advance and statistics.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    gap_d      = gap_q;
    count_d    = count_q;
    seed_d     = seed_q;
    data_d     = data_q;
    lfsr_d     = lfsr_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    pkts_d     = pkts_q;
    beats_d    = beats_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_enable) begin
          mode_d     = cfg_mode;
          len_d      = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
          gap_d      = cfg_gap_len;
          count_d    = cfg_pkt_count;
          seed_d     = cfg_seed;
          data_d     = cfg_seed;
          lfsr_d     = (seed32 == 32'h0) ? 32'h1 : seed32;
          beat_cnt_d = '0;
          gap_cnt_d  = '0;
          pkts_d     = '0;
          beats_d    = '0;
          state_d    = S_SEND;
        end
      end

      S_SEND: begin
        // Everything advances only on a transfer, so a stall holds the beat.
        if (m_axis_tready) begin
          beats_d = beats_q + CNT_WIDTH'(1);
          data_d  = data_q + DATA_WIDTH'(1);
          lfsr_d  = lfsr_step(lfsr_q);
          if (last_beat) begin
            beat_cnt_d = '0;
            pkts_d     = pkts_inc;
            if (count_q != '0 && pkts_inc == count_q) begin
              state_d = S_DONE;
            end else if (!cfg_enable) begin
              state_d = S_IDLE;
            end else if (gap_q == '0) begin
              state_d = S_SEND;
            end else begin
              gap_cnt_d = '0;
              state_d   = S_GAP;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
          end
        end
      end

      S_GAP: begin
        // gap_q is non-zero here; the final gap cycle hands over to SEND.
        if (!cfg_enable) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == gap_q - GAP_WIDTH'(1)) begin
          state_d = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_WIDTH'(1);
        end
      end

      S_DONE: begin
        if (!cfg_enable) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SEND) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  // State, shadow configuration, pattern and status registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      len_q      <= LEN_WIDTH'(1);
      gap_q      <= '0;
      count_q    <= '0;
      seed_q     <= '0;
      data_q     <= '0;
      lfsr_q     <= 32'h1;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      pkts_q     <= '0;
      beats_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      count_q    <= count_d;
      seed_q     <= seed_d;
      data_q     <= data_d;
      lfsr_q     <= lfsr_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pkts_q     <= pkts_d;
      beats_q    <= beats_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Beat data selection; the LFSR word is tiled across wide buses.
  always_comb begin
    lfsr_rep = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      lfsr_rep[i] = lfsr_q[i % 32];
    end
    unique case (mode_q)
      MODE_INCR:  pattern = data_q;
      MODE_CONST: pattern = seed_q;
      MODE_LFSR:  pattern = lfsr_rep;
      MODE_INDEX: pattern = (beat_cnt_q == '0) ? DATA_WIDTH'(pkts_q)
                                               : DATA_WIDTH'(beat_cnt_q);
      default:    pattern = data_q;
    endcase
  end

  assign m_axis_tvalid = (state_q == S_SEND);
  assign m_axis_tkeep  = {KEEP_WIDTH{m_axis_tvalid}};
  assign m_axis_tlast  = m_axis_tvalid && last_beat;
  assign m_axis_tdata  = m_axis_tvalid ? pattern : '0;

  assign stat_busy  = busy_q;
  assign stat_done  = done_q;
  assign stat_pkts  = pkts_q;
  assign stat_beats = beats_q;

endmodule

// File: tb/tb_trafficgen_core.sv
// Directed testbench for trafficgen_core. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_trafficgen_core;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cfg_enable;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_pkt_len;
  logic [15:0] cfg_gap_len;
  logic [31:0] cfg_pkt_count;
  logic [31:0] cfg_seed;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        stat_busy;
  logic        stat_done;
  logic [31:0] stat_pkts;
  logic [31:0] stat_beats;

  int n_checks = 0;
  int n_fail   = 0;

  trafficgen_core #(
    .DATA_WIDTH(32),
    .LEN_WIDTH (16),
    .GAP_WIDTH (16),
    .CNT_WIDTH (32)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_enable   (cfg_enable),
    .cfg_mode     (cfg_mode),
    .cfg_pkt_len  (cfg_pkt_len),
    .cfg_gap_len  (cfg_gap_len),
    .cfg_pkt_count(cfg_pkt_count),
    .cfg_seed     (cfg_seed),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .stat_busy    (stat_busy),
    .stat_done    (stat_done),
    .stat_pkts    (stat_pkts),
    .stat_beats   (stat_beats)
  );

  always #5 aclk = ~aclk;

  task automatic do_reset;
    areset        = 1'b1;
    cfg_enable    = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
  endtask

  task automatic configure(input logic [1:0] mode, input logic [15:0] len,
                           input logic [15:0] gap, input logic [31:0] count,
                           input logic [31:0] seed);
    cfg_mode      = mode;
    cfg_pkt_len   = len;
    cfg_gap_len   = gap;
    cfg_pkt_count = count;
    cfg_seed      = seed;
  endtask

  task automatic test_reset;
    areset        = 1'b1;
    cfg_enable    = 1'b1;
    m_axis_tready = 1'b1;
    configure(2'd0, 16'd4, 16'd0, 32'd0, 32'h10);
    #3;
    n_checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, stat_busy,
         stat_done, stat_pkts, stat_beats} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b l=%b k=%h d=%h busy=%b done=%b pkts=%0d beats=%0d required all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, stat_busy,
               stat_done, stat_pkts, stat_beats);
    end
    cfg_enable = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    n_checks++;
    if ({m_axis_tvalid, stat_busy, stat_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got v=%b busy=%b done=%b required 000",
               m_axis_tvalid, stat_busy, stat_done);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    configure(2'd0, 16'd4, 16'd0, 32'd2, 32'h10);
    cfg_enable = 1'b1;
    @(negedge aclk);
    // Configuration changes mid-run must be ignored.
    configure(2'd1, 16'd2, 16'd5, 32'd9, 32'hFF);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, stat_busy,
           stat_pkts, stat_beats} !==
          {1'b1, 1'(i % 4 == 3), 4'hF, 32'(32'h10 + i), 1'b1, 32'(i / 4), 32'(i)}) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got v=%b l=%b k=%h d=%h busy=%b pkts=%0d beats=%0d required v=1 l=%b k=f d=%h busy=1 pkts=%0d beats=%0d",
                 i, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, stat_busy,
                 stat_pkts, stat_beats, (i % 4 == 3), 32'h10 + i, i / 4, i);
      end
      @(negedge aclk);
    end
    repeat (2) begin
      n_checks++;
      if ({m_axis_tvalid, m_axis_tkeep, stat_done, stat_busy, stat_pkts, stat_beats} !==
          {1'b0, 4'h0, 1'b1, 1'b0, 32'd2, 32'd8}) begin
        n_fail++;
        $display("FAIL b2b_done: got v=%b k=%h done=%b busy=%b pkts=%0d beats=%0d required v=0 k=0 done=1 busy=0 pkts=2 beats=8",
                 m_axis_tvalid, m_axis_tkeep, stat_done, stat_busy, stat_pkts, stat_beats);
      end
      @(negedge aclk);
    end
    cfg_enable = 1'b0;
    @(negedge aclk);
    n_checks++;
    if ({m_axis_tvalid, stat_done, stat_pkts} !== {1'b0, 1'b0, 32'd2}) begin
      n_fail++;
      $display("FAIL done_to_idle: got v=%b done=%b pkts=%0d required v=0 done=0 pkts=2",
               m_axis_tvalid, stat_done, stat_pkts);
    end
  endtask

  task automatic test_gap;
    int k = 0;
    do_reset();
    configure(2'd0, 16'd4, 16'd3, 32'd2, 32'h10);
    cfg_enable = 1'b1;
    @(negedge aclk);
    for (int i = 0; i < 11; i++) begin
      logic exp_v;
      exp_v = !(i >= 4 && i <= 6);
      n_checks++;
      if ({m_axis_tvalid, stat_busy} !== {exp_v, 1'b1} ||
          (exp_v && {m_axis_tdata, m_axis_tlast} !== {32'(32'h10 + k), 1'(k % 4 == 3)})) begin
        n_fail++;
        $display("FAIL gap_cycle%0d: got v=%b busy=%b d=%h l=%b required v=%b busy=1 d=%h l=%b",
                 i, m_axis_tvalid, stat_busy, m_axis_tdata, m_axis_tlast, exp_v,
                 32'h10 + k, (k % 4 == 3));
      end
      if (exp_v) k++;
      @(negedge aclk);
    end
    n_checks++;
    if ({m_axis_tvalid, stat_done, stat_pkts, stat_beats} !== {1'b0, 1'b1, 32'd2, 32'd8}) begin
      n_fail++;
      $display("FAIL gap_done: got v=%b done=%b pkts=%0d beats=%0d required v=0 done=1 pkts=2 beats=8",
               m_axis_tvalid, stat_done, stat_pkts, stat_beats);
    end
  endtask

  task automatic test_backpressure;
    int k   = 0;
    int cyc = 0;
    do_reset();
    configure(2'd0, 16'd8, 16'd0, 32'd1, 32'h10);
    cfg_enable = 1'b1;
    @(negedge aclk);
    while (k < 8 && cyc < 60) begin
      logic rdy;
      n_checks++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast} !== {1'b1, 32'(32'h10 + k), 1'(k == 7)}) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                 cyc, m_axis_tvalid, m_axis_tdata, m_axis_tlast, 32'h10 + k, (k == 7));
      end
      rdy = (cyc % 3 == 0);
      m_axis_tready = rdy;
      @(negedge aclk);
      if (rdy) k++;
      cyc++;
    end
    if (k < 8) begin
      n_checks++;
      n_fail++;
      $display("FAIL bp_timeout: got %0d beats required 8", k);
    end
    m_axis_tready = 1'b1;
    n_checks++;
    if ({m_axis_tvalid, stat_done, stat_pkts, stat_beats} !== {1'b0, 1'b1, 32'd1, 32'd8}) begin
      n_fail++;
      $display("FAIL bp_done: got v=%b done=%b pkts=%0d beats=%0d required v=0 done=1 pkts=1 beats=8",
               m_axis_tvalid, stat_done, stat_pkts, stat_beats);
    end
  endtask

  task automatic test_enable_drop;
    do_reset();
    configure(2'd0, 16'd8, 16'd0, 32'd0, 32'h10);
    cfg_enable = 1'b1;
    @(negedge aclk);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, 1'(i == 7), 32'(32'h10 + i)}) begin
        n_fail++;
        $display("FAIL drop_beat%0d: got v=%b l=%b d=%h required v=1 l=%b d=%h",
                 i, m_axis_tvalid, m_axis_tlast, m_axis_tdata, (i == 7), 32'h10 + i);
      end
      if (i == 3) cfg_enable = 1'b0;
      @(negedge aclk);
    end
    repeat (2) begin
      n_checks++;
      if ({m_axis_tvalid, stat_busy, stat_done, stat_pkts, stat_beats} !==
          {1'b0, 1'b0, 1'b0, 32'd1, 32'd8}) begin
        n_fail++;
        $display("FAIL drop_idle: got v=%b busy=%b done=%b pkts=%0d beats=%0d required v=0 busy=0 done=0 pkts=1 beats=8",
                 m_axis_tvalid, stat_busy, stat_done, stat_pkts, stat_beats);
      end
      @(negedge aclk);
    end
    cfg_enable = 1'b1;
    @(negedge aclk);
    n_checks++;
    if ({m_axis_tvalid, m_axis_tdata, stat_pkts, stat_beats} !== {1'b1, 32'h10, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL drop_restart: got v=%b d=%h pkts=%0d beats=%0d required v=1 d=00000010 pkts=0 beats=0",
               m_axis_tvalid, m_axis_tdata, stat_pkts, stat_beats);
    end
  endtask

  task automatic test_lfsr;
    logic [31:0] exp_lfsr [4] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};
    for (int s = 0; s < 2; s++) begin
      do_reset();
      configure(2'd2, 16'd4, 16'd0, 32'd1, 32'(s));
      cfg_enable = 1'b1;
      @(negedge aclk);
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast} !== {1'b1, exp_lfsr[i], 1'(i == 3)}) begin
          n_fail++;
          $display("FAIL lfsr_seed%0d_beat%0d: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                   s, i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp_lfsr[i], (i == 3));
        end
        @(negedge aclk);
      end
    end
  endtask

  task automatic test_const_and_indexed;
    logic [31:0] exp_idx [6] = '{32'd0, 32'd1, 32'd2, 32'd1, 32'd1, 32'd2};
    do_reset();
    configure(2'd1, 16'd2, 16'd0, 32'd1, 32'hCAFE_F00D);
    cfg_enable = 1'b1;
    @(negedge aclk);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 32'hCAFE_F00D}) begin
        n_fail++;
        $display("FAIL const_beat%0d: got v=%b d=%h required v=1 d=cafef00d",
                 i, m_axis_tvalid, m_axis_tdata);
      end
      @(negedge aclk);
    end
    do_reset();
    configure(2'd3, 16'd3, 16'd0, 32'd2, 32'hDEAD_BEEF);
    cfg_enable = 1'b1;
    @(negedge aclk);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast} !== {1'b1, exp_idx[i], 1'(i % 3 == 2)}) begin
        n_fail++;
        $display("FAIL index_beat%0d: got v=%b d=%h l=%b required v=1 d=%h l=%b",
                 i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp_idx[i], (i % 3 == 2));
      end
      @(negedge aclk);
    end
  endtask

  task automatic test_len_zero;
    do_reset();
    configure(2'd0, 16'd0, 16'd0, 32'd2, 32'h20);
    cfg_enable = 1'b1;
    @(negedge aclk);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, stat_pkts} !==
          {1'b1, 1'b1, 32'(32'h20 + i), 32'(i)}) begin
        n_fail++;
        $display("FAIL len0_beat%0d: got v=%b l=%b d=%h pkts=%0d required v=1 l=1 d=%h pkts=%0d",
                 i, m_axis_tvalid, m_axis_tlast, m_axis_tdata, stat_pkts, 32'h20 + i, i);
      end
      @(negedge aclk);
    end
    n_checks++;
    if ({m_axis_tvalid, stat_done, stat_beats} !== {1'b0, 1'b1, 32'd2}) begin
      n_fail++;
      $display("FAIL len0_done: got v=%b done=%b beats=%0d required v=0 done=1 beats=2",
               m_axis_tvalid, stat_done, stat_beats);
    end
  endtask

  task automatic test_reset_mid_packet;
    do_reset();
    configure(2'd0, 16'd4, 16'd0, 32'd0, 32'h10);
    cfg_enable = 1'b1;
    repeat (3) @(negedge aclk);
    n_checks++;
    if ({m_axis_tvalid, m_axis_tdata, stat_beats} !== {1'b1, 32'h12, 32'd2}) begin
      n_fail++;
      $display("FAIL mid_pre_reset: got v=%b d=%h beats=%0d required v=1 d=00000012 beats=2",
               m_axis_tvalid, m_axis_tdata, stat_beats);
    end
    #2 areset = 1'b1;
    #1;
    n_checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, stat_busy,
         stat_done, stat_pkts, stat_beats} !== '0) begin
      n_fail++;
      $display("FAIL mid_async_reset: got v=%b l=%b k=%h d=%h busy=%b done=%b pkts=%0d beats=%0d required all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, stat_busy,
               stat_done, stat_pkts, stat_beats);
    end
    cfg_enable = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      n_checks++;
      if ({m_axis_tvalid, stat_busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL mid_stay_idle: got v=%b busy=%b required 00", m_axis_tvalid, stat_busy);
      end
    end
    cfg_enable = 1'b1;
    @(negedge aclk);
    n_checks++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, stat_beats} !== {1'b1, 32'h10, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL mid_restart: got v=%b d=%h l=%b beats=%0d required v=1 d=00000010 l=0 beats=0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, stat_beats);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_backpressure();
    test_enable_drop();
    test_lfsr();
    test_const_and_indexed();
    test_len_zero();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
